// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline types and constants used by the hazard controller.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int STAT_W     = 16;

   typedef enum logic {
      RUN        = 1'b0,
      LOAD_STALL = 1'b1
   } hazard_state_t;

   // Register $zero is never a real producer, so it can never cause a load-use hazard.
   function automatic logic load_use_hit(
      input logic                  mem_read,
      input logic [REG_ADDR_W-1:0] ex_rt,
      input logic [REG_ADDR_W-1:0] id_rs,
      input logic [REG_ADDR_W-1:0] id_rt,
      input logic                  uses_rt
   );
      return mem_read && (ex_rt != {REG_ADDR_W{1'b0}}) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used by the memory-wait watchdog and stats.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {W{1'b0}};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// MIPS32 hazard controller: load-use stall, redirect flush, memory freeze and wait watchdog.
// Optional HAZARD_STATS_EN adds load_stall_count and freeze_count outputs.
module hazard_unit
   import mips_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int MAX_WAIT     = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_mem_read,
   input  logic                  pc_redirect,
   input  logic                  mem_busy,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_flush,
   output logic                  ex_stall,
   output logic                  freeze,
   output logic                  stall_timeout
`ifdef HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0]     load_stall_count,
   output logic [STAT_W-1:0]     freeze_count
`endif
);

   localparam logic [2:0]  FIRST_REMAIN_C = 3'(LOAD_BUBBLES - 1);
   localparam logic [16:0] MAX_WAIT_C     = 17'(MAX_WAIT);

   hazard_state_t     state_r, state_nxt_s;
   logic [2:0]        remaining_r, remaining_nxt_s;
   logic              lu_s;
   logic              wait_clr_s;
   logic [STAT_W-1:0] wait_cnt_s;

   assign lu_s = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   // State, bubble counter and sticky timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= RUN;
         remaining_r   <= 3'd0;
         stall_timeout <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         remaining_r <= remaining_nxt_s;
         if (mem_busy && (({1'b0, wait_cnt_s} + 17'd1) >= MAX_WAIT_C)) begin
            stall_timeout <= 1'b1;
         end
      end
   end

   // Mealy next-state and control decode; priority rst > mem_busy > load stall > redirect.
   always_comb begin
      state_nxt_s     = state_r;
      remaining_nxt_s = remaining_r;
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      if_flush        = 1'b0;
      ex_stall        = 1'b0;
      freeze          = 1'b0;
      if (rst) begin
         state_nxt_s     = RUN;
         remaining_nxt_s = 3'd0;
      end else if (mem_busy) begin
         freeze      = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (lu_s) begin
                  ex_stall    = 1'b1;
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  if (LOAD_BUBBLES > 1) begin
                     state_nxt_s     = LOAD_STALL;
                     remaining_nxt_s = FIRST_REMAIN_C;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else if (pc_redirect) begin
                  if_flush = 1'b1;
               end else begin
                  if_flush = 1'b0;
               end
            end
            LOAD_STALL: begin
               // EX already holds a bubble here, so a fresh lu is not re-armed.
               ex_stall        = 1'b1;
               pc_write        = 1'b0;
               if_id_write     = 1'b0;
               remaining_nxt_s = remaining_r - 3'd1;
               if (remaining_r <= 3'd1) begin
                  state_nxt_s     = RUN;
                  remaining_nxt_s = 3'd0;
               end else begin
                  state_nxt_s = LOAD_STALL;
               end
            end
            default: begin
               state_nxt_s     = RUN;
               remaining_nxt_s = 3'd0;
            end
         endcase
      end
   end

   // Any non-busy cycle restarts the consecutive-wait count.
   assign wait_clr_s = rst | ~mem_busy;

   sat_counter #(.W(STAT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (wait_clr_s),
      .inc   (mem_busy),
      .count (wait_cnt_s)
   );

`ifdef HAZARD_STATS_EN
   sat_counter #(.W(STAT_W)) u_load_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ex_stall),
      .count (load_stall_count)
   );

   sat_counter #(.W(STAT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze),
      .count (freeze_count)
   );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (LOAD_BUBBLES 1 and 3, MAX_WAIT 4) share stimulus.
module tb_hazard_unit;

   // Control output order: {pc_write, if_id_write, if_flush, ex_stall, freeze}
   localparam logic [4:0] IDLE  = 5'b11000;
   localparam logic [4:0] STALL = 5'b00010;
   localparam logic [4:0] FLUSH = 5'b11100;
   localparam logic [4:0] FRZ   = 5'b00001;

   typedef struct {
      int         idx;
      logic [4:0] exp_a;
      logic [4:0] exp_b;
      logic       chk_to;
      logic       exp_to;
      logic       chk_stats;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, pc_redirect, mem_busy;

   logic pc_write_a, if_id_write_a, if_flush_a, ex_stall_a, freeze_a, stall_timeout_a;
   logic pc_write_b, if_id_write_b, if_flush_b, ex_stall_b, freeze_b, stall_timeout_b;
`ifdef HAZARD_STATS_EN
   logic [15:0] ls_cnt_a, fz_cnt_a, ls_cnt_b, fz_cnt_b;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   vec_idx = 0;

   hazard_unit #(.LOAD_BUBBLES(1), .MAX_WAIT(4)) u_dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .pc_redirect(pc_redirect), .mem_busy(mem_busy),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_flush(if_flush_a),
      .ex_stall(ex_stall_a), .freeze(freeze_a), .stall_timeout(stall_timeout_a)
`ifdef HAZARD_STATS_EN
      , .load_stall_count(ls_cnt_a), .freeze_count(fz_cnt_a)
`endif
   );

   hazard_unit #(.LOAD_BUBBLES(3), .MAX_WAIT(4)) u_dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .pc_redirect(pc_redirect), .mem_busy(mem_busy),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_flush(if_flush_b),
      .ex_stall(ex_stall_b), .freeze(freeze_b), .stall_timeout(stall_timeout_b)
`ifdef HAZARD_STATS_EN
      , .load_stall_count(ls_cnt_b), .freeze_count(fz_cnt_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus just after the rising edge and queue its expected response.
   task automatic step(
      input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
      input logic [4:0] ert, input logic mr, input logic redir, input logic busy,
      input logic [4:0] ea, input logic [4:0] eb,
      input logic cto, input logic eto, input logic cst
   );
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert;
      ex_mem_read = mr; pc_redirect = redir; mem_busy = busy;
      e.idx = vec_idx; e.exp_a = ea; e.exp_b = eb;
      e.chk_to = cto; e.exp_to = eto; e.chk_stats = cst;
      exp_q.push_back(e);
      vec_idx++;
   endtask

   // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({pc_write_a, if_id_write_a, if_flush_a, ex_stall_a, freeze_a} !== mon_e.exp_a) begin
            errors++;
            $display("FAIL ctl_a vec %0d got %b exp %b", mon_e.idx,
                     {pc_write_a, if_id_write_a, if_flush_a, ex_stall_a, freeze_a}, mon_e.exp_a);
         end
         checks++;
         if ({pc_write_b, if_id_write_b, if_flush_b, ex_stall_b, freeze_b} !== mon_e.exp_b) begin
            errors++;
            $display("FAIL ctl_b vec %0d got %b exp %b", mon_e.idx,
                     {pc_write_b, if_id_write_b, if_flush_b, ex_stall_b, freeze_b}, mon_e.exp_b);
         end
         if (mon_e.chk_to) begin
            checks++;
            if ({stall_timeout_a, stall_timeout_b} !== {2{mon_e.exp_to}}) begin
               errors++;
               $display("FAIL timeout vec %0d got a=%b b=%b exp %b", mon_e.idx,
                        stall_timeout_a, stall_timeout_b, mon_e.exp_to);
            end
         end
`ifdef HAZARD_STATS_EN
         if (mon_e.chk_stats) begin
            checks++;
            if ({ls_cnt_a, fz_cnt_a, ls_cnt_b, fz_cnt_b} !== 64'd0) begin
               errors++;
               $display("FAIL stats vec %0d got %0d %0d %0d %0d exp 0", mon_e.idx,
                        ls_cnt_a, fz_cnt_a, ls_cnt_b, fz_cnt_b);
            end
         end
`endif
      end
   end

   initial begin
      rst = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
      ex_mem_read = 1'b0; pc_redirect = 1'b0; mem_busy = 1'b0;
      //    rst  rs     rt     use   ert    mr    rd    busy  exp_a  exp_b  cto   eto   cst
      // reset and idle
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b1, 1'b0, 1'b1);
      // basic load-use on rs: one bubble for A, three for B
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      // $zero never hazards; rt match only counts when rt is read
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  STALL, 1'b0, 1'b0, 1'b0);
      // redirect arbitration: stall wins, redirect ignored inside LOAD_STALL
      step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, STALL, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH, FLUSH, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      // multi-bubble with freeze in cycle 1; lu held throughout is ignored by B's LOAD_STALL
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      // watchdog: 3 busy cycles do not trip MAX_WAIT=4
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b1, 1'b0, 1'b0);
      // 4 consecutive busy cycles: flag rises on the edge ending the 4th, then sticks
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   FRZ,   1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b1, 1'b1, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b1, 1'b1, 1'b0);
      // reset mid-stall (B has remaining=2), with busy/hazard/redirect all asserted
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, STALL, STALL, 1'b1, 1'b1, 1'b0);
      step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, IDLE,  IDLE,  1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE,  IDLE,  1'b1, 1'b0, 1'b1);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH, FLUSH, 1'b1, 1'b0, 1'b0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) begin
            @(posedge clk);
         end
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
